// File: rtl/r22_pkg.sv
// Shared types and helpers for the R2^2 SDF twiddle path: FSM states,
// converter latency and the twiddle-number mapping.
package r22_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MAX_LAT = 2;

  // Cycles between a twiddle number and its converted value.
  function automatic int unsigned tw_lat(input int unsigned tw_ff, input int unsigned tc_ff);
    return tw_ff + tc_ff;
  endfunction

  // Twiddle number for count c: sel takes the two top count bits swapped,
  // num is the low part scaled up to the full table resolution.
  function automatic int unsigned tw_num(input int unsigned c,
                                         input int unsigned log_n,
                                         input int unsigned log_m);
    int unsigned sel;
    int unsigned num;
    sel = (((c >> (log_m - 32'd2)) & 32'd1) << 1) | ((c >> (log_m - 32'd1)) & 32'd1);
    num = (c & ((32'd1 << (log_m - 32'd2)) - 32'd1)) << (log_n - log_m);
    return (num * sel) & ((32'd1 << log_n) - 32'd1);
  endfunction

endpackage

// File: rtl/twiddle_addr_gen_if.sv
// Twiddle address/value interface between the sequencer (master) and the
// butterfly-side consumer of the aligned flags (slave).
interface twiddle_addr_gen_if #(
  parameter int unsigned LOG_N = 6
);
  logic             di_en;
  logic [LOG_N-1:0] tw_addr;
  logic             tw_en;
  logic             tw_bypass;
  logic             frame_last;
  logic             busy;

  modport master (
    input  di_en,
    output tw_addr, tw_en, tw_bypass, frame_last, busy
  );

  modport slave (
    output di_en,
    input  tw_addr, tw_en, tw_bypass, frame_last, busy
  );
endinterface

// File: rtl/twiddle_addr_gen_delay.sv
// Flag delay line matching the twiddle converter latency; DEPTH=0 is a wire.
module twiddle_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_set
);

  if (DEPTH == 0) begin : g_pass
    assign dout    = din;
    assign any_set = 1'b0;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];

    // Any in-flight flag keeps the block busy.
    always_comb begin
      any_set = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) any_set = any_set | (|stage[i]);
    end
  end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Twiddle-number sequencer for one R2^2 SDF stage: counts samples, emits the
// twiddle number and delays per-sample flags to meet the converted value.
module twiddle_addr_gen
  import r22_pkg::*;
#(
  parameter int unsigned LOG_N = 6,
  parameter int unsigned LOG_M = 6,
  parameter int unsigned TW_FF = 1,
  parameter int unsigned TC_FF = 1
) (
  input  logic               clock,
  input  logic               reset,
  twiddle_addr_gen_if.master tw
);

  localparam int unsigned LAT    = tw_lat(TW_FF, TC_FF);
  localparam int unsigned M_LAST = (32'd1 << LOG_M) - 32'd1;
  localparam int unsigned FLAG_W = 3;

  if (LOG_M < 2 || LOG_M > LOG_N || LAT > MAX_LAT) begin : g_bad_cfg
    $error("twiddle_addr_gen: unsupported LOG_M/LOG_N/latency combination");
  end

  logic [LOG_M-1:0]  cnt;
  state_e            state;
  state_e            state_nxt;
  logic              wrap_c;
  logic              byp0_c;
  logic [FLAG_W-1:0] flags_c;
  logic [FLAG_W-1:0] flags_dly;
  logic              pipe_busy;

  assign wrap_c = tw.di_en & (cnt == LOG_M'(M_LAST));

  // Sample counter; M is a power of two so the wrap is the natural overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tw.di_en) begin
      cnt <= cnt + LOG_M'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tw.di_en && cnt == '0) state_nxt = RUN;
      RUN:  if (wrap_c)                state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  assign tw.tw_addr = LOG_N'(tw_num(32'(cnt), LOG_N, LOG_M));
  assign byp0_c     = (tw.tw_addr == '0);
  assign flags_c    = {tw.di_en, byp0_c & tw.di_en, wrap_c};

  twiddle_delay #(
    .WIDTH (FLAG_W),
    .DEPTH (LAT)
  ) u_delay (
    .clock   (clock),
    .reset   (reset),
    .din     (flags_c),
    .dout    (flags_dly),
    .any_set (pipe_busy)
  );

  assign tw.tw_en      = flags_dly[2];
  assign tw.tw_bypass  = flags_dly[1];
  assign tw.frame_last = flags_dly[0];
  assign tw.busy       = (state == RUN) | pipe_busy;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Bench for twiddle_addr_gen: three configurations share one stimulus stream
// and are checked every cycle against a scoreboard plus a constant table.
module tb_twiddle_addr_gen;
  import r22_pkg::*;

  localparam int unsigned LOG_N = 6;

  typedef struct {
    int unsigned due;
    logic        byp;
    logic        last;
  } exp_t;

  typedef struct {
    int unsigned n_en;
    int unsigned a;
    int unsigned b;
    int unsigned c;
  } vec_t;

  logic clock;
  logic reset;
  logic di_en;

  twiddle_addr_gen_if #(.LOG_N(LOG_N)) bus_a ();
  twiddle_addr_gen_if #(.LOG_N(LOG_N)) bus_b ();
  twiddle_addr_gen_if #(.LOG_N(LOG_N)) bus_c ();

  assign bus_a.di_en = di_en;
  assign bus_b.di_en = di_en;
  assign bus_c.di_en = di_en;

  twiddle_addr_gen #(.LOG_N(6), .LOG_M(6), .TW_FF(1), .TC_FF(1)) dut_a (
    .clock (clock), .reset (reset), .tw (bus_a));
  twiddle_addr_gen #(.LOG_N(6), .LOG_M(4), .TW_FF(1), .TC_FF(1)) dut_b (
    .clock (clock), .reset (reset), .tw (bus_b));
  twiddle_addr_gen #(.LOG_N(6), .LOG_M(6), .TW_FF(0), .TC_FF(0)) dut_c (
    .clock (clock), .reset (reset), .tw (bus_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_vec;
  int unsigned n_miss;
  int unsigned cyc;
  int unsigned lat_m   [3];
  int unsigned log_m_m [3];
  int unsigned c_m     [3];
  logic        run_m   [3];
  exp_t        sb      [3][$];

  logic [LOG_N-1:0] addr_s [3];
  logic             en_s   [3];
  logic             byp_s  [3];
  logic             last_s [3];
  logic             busy_s [3];

  int unsigned fl_cnt;
  int unsigned fl_prev;
  int unsigned fl_gap;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic sample_all();
    addr_s[0] = bus_a.tw_addr; en_s[0] = bus_a.tw_en; byp_s[0] = bus_a.tw_bypass;
    last_s[0] = bus_a.frame_last; busy_s[0] = bus_a.busy;
    addr_s[1] = bus_b.tw_addr; en_s[1] = bus_b.tw_en; byp_s[1] = bus_b.tw_bypass;
    last_s[1] = bus_b.frame_last; busy_s[1] = bus_b.busy;
    addr_s[2] = bus_c.tw_addr; en_s[2] = bus_c.tw_en; byp_s[2] = bus_c.tw_bypass;
    last_s[2] = bus_c.frame_last; busy_s[2] = bus_c.busy;
  endtask

  // Scoreboard step for one configuration in the current cycle.
  task automatic check_dut(input int d, input logic en, input logic rst);
    int unsigned      m_last;
    logic [LOG_N-1:0] ea;
    logic             eb;
    logic             ee;
    logic             ebyp;
    logic             elast;
    exp_t             e;
    m_last = (32'd1 << log_m_m[d]) - 32'd1;
    ea     = LOG_N'(tw_num(c_m[d], LOG_N, log_m_m[d]));
    eb     = run_m[d];
    for (int i = 0; i < sb[d].size(); i++)
      if (sb[d][i].due < cyc + lat_m[d]) eb = 1'b1;
    if (rst && en) begin
      e.due  = cyc + lat_m[d];
      e.byp  = (ea == '0);
      e.last = (c_m[d] == m_last);
      sb[d].push_back(e);
    end
    ee = 1'b0; ebyp = 1'b0; elast = 1'b0;
    if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
      ee    = 1'b1;
      ebyp  = sb[d][0].byp;
      elast = sb[d][0].last;
      void'(sb[d].pop_front());
    end
    chk("tw_addr",    d, 32'(addr_s[d]), 32'(ea));
    chk("tw_en",      d, 32'(en_s[d]),   32'(ee));
    chk("tw_bypass",  d, 32'(byp_s[d]),  32'(ebyp));
    chk("frame_last", d, 32'(last_s[d]), 32'(elast));
    chk("busy",       d, 32'(busy_s[d]), 32'(eb));
    if (d == 0 && last_s[0] === 1'b1) begin
      fl_gap  = cyc - fl_prev;
      fl_prev = cyc;
      fl_cnt++;
    end
    if (!rst) begin
      c_m[d]   = 0;
      run_m[d] = 1'b0;
      sb[d].delete();
    end else if (en) begin
      if (c_m[d] == m_last) begin
        c_m[d]   = 0;
        run_m[d] = 1'b0;
      end else begin
        c_m[d]   = c_m[d] + 1;
        run_m[d] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic en, input logic rst);
    @(negedge clock);
    di_en = en;
    reset = rst;
    #1;
    sample_all();
    for (int d = 0; d < 3; d++) check_dut(d, en, rst);
    cyc++;
  endtask

  vec_t vt [11];

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0;
    fl_cnt = 0; fl_prev = 0; fl_gap = 0;
    lat_m   = '{2, 2, 0};
    log_m_m = '{6, 4, 6};
    c_m     = '{0, 0, 0};
    run_m   = '{1'b0, 1'b0, 1'b0};
    reset   = 1'b0;
    di_en   = 1'b0;

    // {samples after reset, addr LOG_M=6, addr LOG_M=4, addr LOG_M=6 LAT=0}
    vt[0]  = '{0,  0,  0,  0};
    vt[1]  = '{5,  0,  8,  0};
    vt[2]  = '{15, 0,  36, 0};
    vt[3]  = '{16, 0,  0,  0};
    vt[4]  = '{17, 2,  0,  2};
    vt[5]  = '{21, 10, 8,  10};
    vt[6]  = '{30, 28, 24, 28};
    vt[7]  = '{33, 1,  0,  1};
    vt[8]  = '{49, 3,  0,  3};
    vt[9]  = '{63, 45, 36, 45};
    vt[10] = '{64, 0,  0,  0};

    for (int v = 0; v < 11; v++) begin
      step(1'b0, 1'b0);
      repeat (vt[v].n_en) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("tbl_addr_m64",     0, 32'(addr_s[0]), vt[v].a);
      chk("tbl_addr_m16",     1, 32'(addr_s[1]), vt[v].b);
      chk("tbl_addr_m64_lat0", 2, 32'(addr_s[2]), vt[v].c);
    end

    // Back-to-back frames: two frame_last pulses exactly one frame apart.
    step(1'b0, 1'b0);
    fl_cnt = 0;
    repeat (128) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("b2b_last_count", 0, fl_cnt, 2);
    chk("b2b_last_gap",   0, fl_gap, 64);

    // Gaps inside a frame, fixed prefix then random.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    repeat (200) step(1'($urandom_range(0, 1)), 1'b1);
    repeat (3) step(1'b0, 1'b1);

    // Reset in the middle of a frame at c=20.
    step(1'b0, 1'b0);
    fl_cnt = 0;
    repeat (20) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("rst_busy",  0, 32'(busy_s[0]), 0);
    chk("rst_tw_en", 0, 32'(en_s[0]),   0);
    chk("rst_addr",  0, 32'(addr_s[0]), 0);
    step(1'b0, 1'b1);
    chk("rst_tw_en2", 0, 32'(en_s[0]), 0);
    step(1'b1, 1'b1);
    chk("restart_addr", 0, 32'(addr_s[0]), 0);
    repeat (4) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("rst_no_last", 0, fl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
